// File: rtl/risc_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package risc_pkg;

    // Arbiter sequencing: pick a winner, drive one access cycle, then wait for read data.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Requester indices as seen by the round-robin picker.
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // Default memory read latency (cs cycle to valid dout).
    localparam int RD_LAT_DEFAULT = 1;

    // Latency counter width; holds read latencies up to 7.
    localparam int LAT_CNT_W = 3;

    // Two-way round-robin choice: on contention the port that did not win last time
    // goes next; a lone requester always wins.
    function automatic logic rr_winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin winner selection with its last-grant history register.
module rr_pick2
    import risc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic winner,
    output logic any_req
);

    logic last_grant_q;
    logic last_grant_d;

    assign any_req = req0 | req1;
    assign winner  = rr_winner(req0, req1, last_grant_q);

    // Remember who was served only when a grant actually takes effect.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = winner;
        end
    end

    // History starts at the debug port so the core port wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PORT_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises two requesters onto the single-port data memory and routes read data back.
module mem_port_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    // port 0: core datapath
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    // port 1: debug / host
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    // memory side
    output logic              mem_cs,
    output logic              mem_r_wbar,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

    arb_state_t          state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                cs_q, cs_d;
    logic                r_wbar_q, r_wbar_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;

    logic                winner;
    logic                any_req;
    logic                accept;
    logic                capture;

    logic                we_sel;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;

    // A grant can only be taken while idle; everything else waits.
    assign accept = (state_q == IDLE) && any_req;

    rr_pick2 u_pick (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .accept  (accept),
        .winner  (winner),
        .any_req (any_req)
    );

    assign gnt0 = accept && (winner == PORT_CORE);
    assign gnt1 = accept && (winner == PORT_DBG);

    // Winning port's command fields, sampled on the grant edge.
    assign we_sel    = winner ? we1    : we0;
    assign addr_sel  = winner ? addr1  : addr0;
    assign wdata_sel = winner ? wdata1 : wdata0;

    // Next-state and memory-command logic; address/data stay put until the next grant.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        cs_d     = cs_q;
        r_wbar_d = r_wbar_q;
        addr_d   = addr_q;
        din_d    = din_q;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_d = 1'b0;
                if (accept) begin
                    owner_d  = winner;
                    cs_d     = 1'b1;
                    r_wbar_d = ~we_sel;
                    addr_d   = addr_sel;
                    if (we_sel) begin
                        din_d = wdata_sel;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Chip select is a single-cycle strobe.
                cs_d = 1'b0;
                if (r_wbar_q) begin
                    cnt_d   = LAT_INIT;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_ONE) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - LAT_ONE;
                end
            end
            default: begin
                cs_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and memory-command registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= PORT_CORE;
            cs_q     <= 1'b0;
            r_wbar_q <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            cs_q     <= cs_d;
            r_wbar_q <= r_wbar_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign mem_cs     = cs_q;
    assign mem_r_wbar = r_wbar_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;

    // Per-port response registers: only the owner of the completing read is touched.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        localparam logic PORT_ID = 1'(gi);

        logic              rvalid_q, rvalid_d;
        logic [DATA_W-1:0] rdata_q, rdata_d;

        // Pulse valid and latch data when this port's read completes.
        always_comb begin
            rvalid_d = capture && (owner_q == PORT_ID);
            rdata_d  = rdata_q;
            if (rvalid_d) begin
                rdata_d = mem_dout;
            end
        end

        // Response state for this port.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                rdata_q  <= rdata_d;
            end
        end
    end

    assign rvalid0 = g_resp[0].rvalid_q;
    assign rdata0  = g_resp[0].rdata_q;
    assign rvalid1 = g_resp[1].rvalid_q;
    assign rdata1  = g_resp[1].rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port 16x16 data memory between two requesters:
  - port 0: instruction_decoder-side datapath;
  - port 1: debug/host port, e.g. a VIO-driven load/inspect path.
- Serialises accesses, drives the memory's cs/r_wbar/addr/din, and returns read data to the winning port.
- Sits between the requesters and the memory; the memory is unchanged.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 16, memory data width.
- RD_LAT, 1, cycles from the cs-asserted cycle until memory dout is valid. Range 1..7.

Ports:
- clk  in  1  clock, shared with the memory.
- rst  in  1  reset; asynchronous, active-high.
- req0  in  1  port 0 access request, level.
- we0  in  1  port 0 access type: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 request accepted this cycle (combinational pulse).
- rvalid0  out  1  port 0 read data valid, one-cycle pulse.
- rdata0  out  DATA_W  port 0 read data, held until the next port 0 read completes.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_cs  out  1  memory chip select.
- mem_r_wbar  out  1  memory access type: 1 = read, 0 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data.

Behaviour:
- Reset values:
  - mem_cs=0, mem_r_wbar=1, mem_addr=0, mem_din=0.
  - rvalid0/1=0, rdata0/1=0.
  - state=IDLE; last_grant=1, so port 0 wins the first contention.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high, pick a winner. Both high: the port != last_grant wins. Single request: that port wins.
  - Assert gnt of the winner combinationally in this cycle. we/addr/wdata are sampled at this cycle's edge.
  - Registered transitions on that edge: mem_cs<=1, mem_r_wbar<=~we, mem_addr, mem_din (write only, else hold); last_grant<=winner; state->ISSUE.
  - No req: stay in IDLE, mem_cs=0.
- ISSUE (exactly 1 cycle, mem_cs=1):
  - On exit, mem_cs<=0.
  - Write -> IDLE.
  - Read -> WAIT, with latency counter loaded to RD_LAT.
- WAIT:
  - Decrement the counter each cycle.
  - At the edge where the counter reaches 1, capture mem_dout into rdata of the winning port, set that port's rvalid<=1 for one cycle, state->IDLE.
- Latency, gnt at cycle 0:
  - Write: mem_cs high in cycle 1; next gnt possible in cycle 2.
  - Read: rvalid in cycle 2+RD_LAT; the next gnt may be in the same cycle as rvalid.
- gnt is never asserted outside IDLE. At most one gnt per cycle, and gnt0 and gnt1 are never both high.
- req is level-sensitive:
  - A requester that keeps req high after gnt is re-arbitrated as a new request.
  - Dropping req before gnt withdraws it with no side effect.
- Fairness under continuous contention: grants strictly alternate 0,1,0,1. No port waits more than one transaction.
- rdata of the non-winning port is never modified. rvalid never fires for writes.
- Reset mid-operation:
  - Abort immediately and return to reset values.
  - No rvalid and no further mem_cs for the aborted access. last_grant returns to 1.
- mem_din/mem_addr are held stable throughout ISSUE and WAIT.

Decomposition:
- Shared package (risc_pkg):
  - state enum arb_state_t {IDLE, ISSUE, WAIT};
  - port index constants PORT_CORE=0, PORT_DBG=1;
  - default RD_LAT constant.
- Sub-module rr_pick2: 2-way round-robin winner select plus the last_grant register. Inputs: req0, req1, accept strobe. Outputs: winner, any_req.
- The FSM, latency counter and response registers stay in mem_port_arbiter.

Test Plan:
- Reset then port 0 read: memory preloaded mem[6]=16'h0032, req0=1, we0=0, addr0=4'h6 -> gnt0 in cycle 0; mem_cs=1, mem_r_wbar=1, mem_addr=6 in cycle 1; rvalid0=1 with rdata0=16'h0032 in cycle 3 (RD_LAT=1); rvalid1 stays 0.
- Port 1 write then port 0 readback: req1 write addr 4'hA, wdata1=16'h1234, then req0 read addr 4'hA -> mem_cs with mem_r_wbar=0 and mem_din=16'h1234 for exactly 1 cycle; no rvalid for the write; rdata0=16'h1234.
- Contention: req0 and req1 both held high for 8 reads -> grants alternate starting with port 0 (0,1,0,1,...); each rvalid goes only to its own port.
- Simultaneous requests after a port 0 grant: last_grant=0, both req -> gnt1 first; a single req0 afterwards -> gnt0 immediately.
- Reset mid-read: assert rst during WAIT -> all outputs return to reset values in the same cycle; no rvalid follows after release; the next contention grants port 0.
- RD_LAT=3 build: read of mem[7]=16'h0050 -> rvalid at cycle 5 after gnt; gnt never asserted during cycles 1-4 even with req1 high.
